skew_delay_line: RTL and testbench

Parametrised per-lane staircase delay line for the systolic-array datapath. One instance serves both roles: it skews operand rows entering the array, and it de-skews result columns leaving it. Each lane carries a per-lane valid bit alongside its data. The block adds a global advance (stall) control, a valid-clearing flush, optional zeroing of invalid lanes and a pipeline-occupancy flag.

---
 rtl/GEMM_pkg.sv | 14 +
 rtl/delay_line_lane.sv | 65 ++++++
 rtl/skew_delay_line.sv | 49 ++++
 tb/tb_skew_delay_line.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/GEMM_pkg.sv
// Shared GEMM datapath types and helpers.
// lane_delay() is the single source of truth for per-lane staircase depth.
package GEMM_pkg;

  typedef enum logic {SKEW_ASC, SKEW_DESC} skew_mode_t;

  function automatic int lane_delay(skew_mode_t mode, int base, int sa_size, int c);
    if (mode == SKEW_ASC) begin
      return base + c;
    end
    return base + sa_size - 1 - c;
  endfunction

endpackage

// File: rtl/delay_line_lane.sv
// One lane of the staircase: DEPTH stages of {valid, data}, or a wire when DEPTH=0.
// Valid bits are authoritative; data registers only follow adv.
module delay_line_lane #(
  parameter int DEPTH        = 1,
  parameter int DATA_WIDTH   = 32,
  parameter bit ZERO_INVALID = 1'b1
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  adv,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  output logic                  busy
);

  if (DEPTH == 0) begin : g_pass
    // Zero-depth lane ignores the pipeline controls entirely.
    logic unused_ctrl;
    assign unused_ctrl = ^{clk, resetn, adv, flush};
    assign out_valid   = in_valid;
    assign out_data    = (ZERO_INVALID && !in_valid) ? '0 : in_data;
    assign busy        = 1'b0;
  end else begin : g_reg
    logic [DEPTH-1:0]      valid_q, valid_d;
    logic [DATA_WIDTH-1:0] data_q [DEPTH];
    logic [DATA_WIDTH-1:0] data_d [DEPTH];

    always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      if (adv) begin
        data_d[0]  = in_data;
        valid_d[0] = in_valid;
        for (int k = 1; k < DEPTH; k++) begin
          data_d[k]  = data_q[k-1];
          valid_d[k] = valid_q[k-1];
        end
      end
      // Flush wins over shifting for valid bits, including the incoming beat.
      if (flush) begin
        valid_d = '0;
      end
    end

    always_ff @(posedge clk) begin
      if (!resetn) begin
        valid_q <= '0;
        for (int k = 0; k < DEPTH; k++) begin
          data_q[k] <= '0;
        end
      end else begin
        valid_q <= valid_d;
        data_q  <= data_d;
      end
    end

    assign out_valid = valid_q[DEPTH-1];
    assign out_data  = (ZERO_INVALID && !valid_q[DEPTH-1]) ? '0 : data_q[DEPTH-1];
    assign busy      = |valid_q;
  end

endmodule

// File: rtl/skew_delay_line.sv
// Per-lane staircase delay line: skews operands into the systolic array or de-skews results out.
// Lane depth comes from lane_delay(); busy is the OR of every registered valid bit.
module skew_delay_line
  import GEMM_pkg::*;
#(
  parameter int         SA_SIZE      = 8,
  parameter int         DATA_WIDTH   = 32,
  parameter skew_mode_t MODE         = SKEW_ASC,
  parameter int         BASE_LAT     = 1,
  parameter bit         ZERO_INVALID = 1'b1
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  adv,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] in_data   [SA_SIZE],
  input  logic [SA_SIZE-1:0]    in_valid,
  output logic [DATA_WIDTH-1:0] out_data  [SA_SIZE],
  output logic [SA_SIZE-1:0]    out_valid,
  output logic                  busy
);

  if (SA_SIZE < 1 || BASE_LAT < 0 || (SA_SIZE > 1 && BASE_LAT + SA_SIZE - 1 < 1)) begin : g_bad_cfg
    $error("skew_delay_line: illegal SA_SIZE/BASE_LAT combination");
  end

  logic [SA_SIZE-1:0] lane_busy;

  for (genvar gi = 0; gi < SA_SIZE; gi++) begin : g_lane
    delay_line_lane #(
      .DEPTH       (lane_delay(MODE, BASE_LAT, SA_SIZE, gi)),
      .DATA_WIDTH  (DATA_WIDTH),
      .ZERO_INVALID(ZERO_INVALID)
    ) u_lane (
      .clk      (clk),
      .resetn   (resetn),
      .adv      (adv),
      .flush    (flush),
      .in_data  (in_data[gi]),
      .in_valid (in_valid[gi]),
      .out_data (out_data[gi]),
      .out_valid(out_valid[gi]),
      .busy     (lane_busy[gi])
    );
  end

  assign busy = |lane_busy;

endmodule

// File: tb/tb_skew_delay_line.sv
// Bench for skew_delay_line: three 4-lane configurations share one stimulus stream and are
// checked every cycle against a history-of-advancing-beats model plus hand-computed literals.
module tb_skew_delay_line;
  import GEMM_pkg::*;

  localparam int N = 4;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         resetn = 1'b0;
  logic         adv = 1'b1;
  logic         flush = 1'b0;
  logic [W-1:0] in_data [N];
  logic [N-1:0] in_valid = '0;

  logic [W-1:0] a_out_data [N];
  logic [W-1:0] d_out_data [N];
  logic [W-1:0] r_out_data [N];
  logic [N-1:0] a_out_valid, d_out_valid, r_out_valid;
  logic         a_busy, d_busy, r_busy;
  logic [N*W-1:0] a_od, d_od, r_od;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  bit check_en = 1'b0;

  always #5 clk = ~clk;

  // A: ascending, base 1, zeroing. D: descending, base 0 (lane 3 is a wire). R: as A but raw data.
  skew_delay_line #(.SA_SIZE(N), .DATA_WIDTH(W), .MODE(SKEW_ASC), .BASE_LAT(1), .ZERO_INVALID(1'b1)) u_a (
    .clk(clk), .resetn(resetn), .adv(adv), .flush(flush), .in_data(in_data), .in_valid(in_valid),
    .out_data(a_out_data), .out_valid(a_out_valid), .busy(a_busy));
  skew_delay_line #(.SA_SIZE(N), .DATA_WIDTH(W), .MODE(SKEW_DESC), .BASE_LAT(0), .ZERO_INVALID(1'b1)) u_d (
    .clk(clk), .resetn(resetn), .adv(adv), .flush(flush), .in_data(in_data), .in_valid(in_valid),
    .out_data(d_out_data), .out_valid(d_out_valid), .busy(d_busy));
  skew_delay_line #(.SA_SIZE(N), .DATA_WIDTH(W), .MODE(SKEW_ASC), .BASE_LAT(1), .ZERO_INVALID(1'b0)) u_r (
    .clk(clk), .resetn(resetn), .adv(adv), .flush(flush), .in_data(in_data), .in_valid(in_valid),
    .out_data(r_out_data), .out_valid(r_out_valid), .busy(r_busy));

  assign a_od = {a_out_data[3], a_out_data[2], a_out_data[1], a_out_data[0]};
  assign d_od = {d_out_data[3], d_out_data[2], d_out_data[1], d_out_data[0]};
  assign r_od = {r_out_data[3], r_out_data[2], r_out_data[1], r_out_data[0]};

  // Model: the list of beats accepted on advancing edges, newest last. A lane of depth D
  // shows the beat D advancing edges old; flush invalidates everything already accepted.
  typedef struct packed {
    logic [N-1:0]   v;
    logic [N*W-1:0] d;
  } beat_t;

  beat_t hist[$];
  beat_t new_beat;

  always @(posedge clk) begin
    if (!resetn) begin
      hist.delete();
    end else begin
      if (flush) begin
        foreach (hist[i]) hist[i].v = '0;
      end
      if (adv) begin
        new_beat.v = flush ? '0 : in_valid;
        new_beat.d = {in_data[3], in_data[2], in_data[1], in_data[0]};
        hist.push_back(new_beat);
        if (hist.size() > 16) void'(hist.pop_front());
      end
    end
  end

  task automatic model_lane(input int dly, input bit zi, input int c,
                            output logic v, output logic [W-1:0] d);
    if (dly == 0) begin
      v = in_valid[c];
      d = in_data[c];
    end else if (hist.size() < dly) begin
      v = 1'b0;
      d = '0;
    end else begin
      v = hist[hist.size() - dly].v[c];
      d = hist[hist.size() - dly].d[c*W +: W];
    end
    if (zi && !v) d = '0;
  endtask

  task automatic check_inst(input string nm, input skew_mode_t mode, input int base, input bit zi,
                            input logic [N-1:0] ov, input logic [N*W-1:0] od, input logic bsy);
    logic         ev;
    logic [W-1:0] ed;
    logic         eb;
    int           dly;
    eb = 1'b0;
    for (int c = 0; c < N; c++) begin
      dly = lane_delay(mode, base, N, c);
      model_lane(dly, zi, c, ev, ed);
      checks++;
      if (ov[c] !== ev) begin
        errors++;
        $display("FAIL %s lane%0d out_valid cyc=%0d: got %0b want %0b", nm, c, cyc, ov[c], ev);
      end
      checks++;
      if (od[c*W +: W] !== ed) begin
        errors++;
        $display("FAIL %s lane%0d out_data cyc=%0d: got %h want %h", nm, c, cyc, od[c*W +: W], ed);
      end
      for (int k = 1; k <= dly; k++) begin
        if (k <= hist.size() && hist[hist.size() - k].v[c]) eb = 1'b1;
      end
    end
    checks++;
    if (bsy !== eb) begin
      errors++;
      $display("FAIL %s busy cyc=%0d: got %0b want %0b", nm, cyc, bsy, eb);
    end
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      check_inst("asc",  SKEW_ASC,  1, 1'b1, a_out_valid, a_od, a_busy);
      check_inst("desc", SKEW_DESC, 0, 1'b1, d_out_valid, d_od, d_busy);
      check_inst("raw",  SKEW_ASC,  1, 1'b0, r_out_valid, r_od, r_busy);
    end
  end

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d: got %h want %h", nm, cyc, act, exp);
    end
  endtask

  // One cycle of stimulus; returns at the following negedge with outputs settled.
  task automatic drive(input logic rn, input logic a, input logic f, input logic [N-1:0] v,
                       input logic [W-1:0] d0, input logic [W-1:0] d1,
                       input logic [W-1:0] d2, input logic [W-1:0] d3);
    @(posedge clk);
    #1;
    cyc++;
    resetn = rn; adv = a; flush = f; in_valid = v;
    in_data[0] = d0; in_data[1] = d1; in_data[2] = d2; in_data[3] = d3;
    $display("cyc=%0d resetn=%0b adv=%0b flush=%0b in_valid=%h in_data0=%h", cyc, rn, a, f, v, d0);
    @(negedge clk);
  endtask

  task automatic idle();
    drive(1'b1, 1'b1, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    for (int c = 0; c < N; c++) in_data[c] = 32'h55;
    in_valid = 4'hF;
    check_en = 1'b1;

    // Reset held for two cycles with all lanes presenting valid beats.
    for (int k = 0; k < 2; k++) begin
      drive(1'b0, 1'b1, 1'b0, 4'hF, 32'h55, 32'h55, 32'h55, 32'h55);
      chk("reset_valid", {28'h0, a_out_valid}, 32'h0);
      chk("reset_busy", {31'h0, a_busy}, 32'h0);
      chk("reset_data0", a_out_data[0], 32'h0);
      chk("reset_raw_data3", r_out_data[3], 32'h0);
    end
    idle();
    chk("post_reset_valid", {28'h0, a_out_valid}, 32'h0);
    chk("post_reset_busy", {31'h0, a_busy}, 32'h0);
    idle();

    // Staircase: lane c of the ascending instance shows its beat exactly 1+c cycles later.
    drive(1'b1, 1'b1, 1'b0, 4'hF, 32'h10, 32'h11, 32'h12, 32'h13);
    chk("desc_pass_l3_valid", {31'h0, d_out_valid[3]}, 32'h1);
    chk("desc_pass_l3_data", d_out_data[3], 32'h13);
    for (int k = 1; k <= 5; k++) begin
      idle();
      for (int c = 0; c < N; c++) begin
        chk("stair_valid", {31'h0, a_out_valid[c]}, (k == c + 1) ? 32'h1 : 32'h0);
        if (k == c + 1) chk("stair_data", a_out_data[c], 32'h10 + c);
      end
      if (k == 3) chk("desc_l0_data", d_out_data[0], 32'h10);
      if (k == 4) chk("stair_busy_last", {31'h0, a_busy}, 32'h1);
      if (k == 5) chk("stair_busy_drop", {31'h0, a_busy}, 32'h0);
    end

    // Stall: three cycles of adv=0 (with ignored valid input) stretch the latency to 7.
    drive(1'b1, 1'b1, 1'b0, 4'hF, 32'h20, 32'h21, 32'h22, 32'h23);
    for (int k = 1; k <= 3; k++) begin
      drive(1'b1, 1'b0, 1'b0, 4'hF, 32'h99, 32'h99, 32'h99, 32'h99);
      chk("stall_l0_valid", {31'h0, a_out_valid[0]}, 32'h1);
      chk("stall_l0_data", a_out_data[0], 32'h20);
      chk("stall_l3_valid", {31'h0, a_out_valid[3]}, 32'h0);
    end
    for (int k = 4; k <= 8; k++) begin
      idle();
      if (k == 4) chk("stall_l0_hold", a_out_data[0], 32'h20);
      if (k == 6) chk("stall_l3_early", {31'h0, a_out_valid[3]}, 32'h0);
      if (k == 7) chk("stall_l3_data", a_out_data[3], 32'h23);
    end

    // Flush at beat 5 of an 8-beat stream; beats 6..8 must still emerge.
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 1'b1, (i == 5), 4'hF, 32'h300 + 16*i, 32'h301 + 16*i, 32'h302 + 16*i, 32'h303 + 16*i);
      if (i == 6) begin
        chk("flush_busy", {31'h0, a_busy}, 32'h0);
        chk("flush_valid", {28'h0, a_out_valid}, 32'h0);
      end
      if (i == 7) chk("flush_beat6_l0", a_out_data[0], 32'h360);
    end
    for (int k = 1; k <= 6; k++) begin
      idle();
      if (k == 2) chk("flush_beat6_l3", a_out_data[3], 32'h363);
      if (k == 4) chk("flush_beat8_l3", a_out_data[3], 32'h383);
    end

    // Flush while stalled: valid clears, raw data stays put.
    drive(1'b1, 1'b1, 1'b0, 4'hF, 32'h40, 32'h41, 32'h42, 32'h43);
    drive(1'b1, 1'b0, 1'b1, 4'h0, 32'h0, 32'h0, 32'h0, 32'h0);
    idle();
    chk("stallflush_valid", {31'h0, a_out_valid[0]}, 32'h0);
    chk("stallflush_rawhold", r_out_data[0], 32'h40);
    chk("stallflush_busy", {31'h0, a_busy}, 32'h0);
    for (int k = 0; k < 4; k++) idle();

    // Reset mid-stream drops everything in flight.
    drive(1'b1, 1'b1, 1'b0, 4'hF, 32'h50, 32'h51, 32'h52, 32'h53);
    drive(1'b0, 1'b1, 1'b0, 4'hF, 32'h60, 32'h61, 32'h62, 32'h63);
    idle();
    chk("midreset_valid", {28'h0, a_out_valid}, 32'h0);
    chk("midreset_busy", {31'h0, a_busy}, 32'h0);
    for (int k = 0; k < 5; k++) idle();

    // Invalid lanes: zeroed on the zeroing instance, raw data visible otherwise.
    for (int k = 0; k <= 5; k++) begin
      drive(1'b1, 1'b1, 1'b0, 4'h0, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF);
      if (k == 5) begin
        for (int c = 0; c < N; c++) begin
          chk("zi_zeroed", a_out_data[c], 32'h0);
          chk("zi_raw", r_out_data[c], 32'hDEADBEEF);
        end
      end
    end

    check_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
